// File: rtl/rz_sprite_render.sv
// rz_sprite_render: 3-stage palette lookup and alpha blend of the rz sprite over the background.
// Define RZ_FADE_EN to compile in the per-frame fade-in FSM; otherwise alpha is fixed at 16.
module rz_sprite_render (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        is_rz,
    input  logic [15:0] rz_addr,
    input  logic [23:0] bg_rgb,
    output logic [15:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        rz_drawn
);

    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] c;
        unique case (idx)
            4'd0:  c = 24'h000000;
            4'd1:  c = 24'h000000;
            4'd2:  c = 24'hFFFFFF;
            4'd3:  c = 24'h808080;
            4'd4:  c = 24'hC0C0C0;
            4'd5:  c = 24'hE02020;
            4'd6:  c = 24'h20E020;
            4'd7:  c = 24'h2020E0;
            4'd8:  c = 24'hE0E020;
            4'd9:  c = 24'h20E0E0;
            4'd10: c = 24'hE020E0;
            4'd11: c = 24'h804000;
            4'd12: c = 24'hFF8000;
            4'd13: c = 24'h400080;
            4'd14: c = 24'h008040;
            4'd15: c = 24'h404040;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    assign rom_addr = rz_addr;

    // Stage 1: waiting on ROM; stage 2: palette registered; stage 3: blended output.
    logic        is_rz_s1_q, is_rz_s2_q;
    logic [23:0] bg_s1_q, bg_s2_q;
    logic        opaque_s2_q;
    logic [23:0] spr_s2_q;
    logic [23:0] rgb_q, rgb_d;
    logic        drawn_q, drawn_d;
    logic [23:0] sprite_rgb;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_rz_s1_q  <= 1'b0;
            bg_s1_q     <= '0;
            is_rz_s2_q  <= 1'b0;
            bg_s2_q     <= '0;
            opaque_s2_q <= 1'b0;
            spr_s2_q    <= '0;
            rgb_q       <= '0;
            drawn_q     <= 1'b0;
        end else begin
            is_rz_s1_q  <= is_rz;
            bg_s1_q     <= bg_rgb;
            is_rz_s2_q  <= is_rz_s1_q;
            bg_s2_q     <= bg_s1_q;
            opaque_s2_q <= (rom_data != 4'd0);
            spr_s2_q    <= palette(rom_data);
            rgb_q       <= rgb_d;
            drawn_q     <= drawn_d;
        end
    end

`ifdef RZ_FADE_EN
    typedef enum logic [1:0] {StHidden, StFadeIn, StShown} fade_state_e;

    fade_state_e state_q, state_d;
    logic [3:0]  fade_cnt_q, fade_cnt_d;
    logic        seen_q, seen_d, seen_now;
    logic [2:0]  fc_sync_q;
    logic        frame_tick;
    logic [4:0]  alpha;

    function automatic logic [7:0] blend(input logic [7:0] spr, input logic [7:0] bg,
                                         input logic [4:0] a);
        logic [11:0] acc;
        acc = {4'd0, spr} * {7'd0, a} + {4'd0, bg} * {7'd0, 5'd16 - a};
        return acc[11:4];
    endfunction

    // Two synchroniser flops, third flop for the rising-edge compare.
    assign frame_tick = fc_sync_q[1] & ~fc_sync_q[2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_sync_q  <= '0;
            seen_q     <= 1'b0;
            fade_cnt_q <= '0;
            state_q    <= StHidden;
        end else begin
            fc_sync_q  <= {fc_sync_q[1:0], frame_clk};
            seen_q     <= seen_d;
            fade_cnt_q <= fade_cnt_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fade_cnt_d = fade_cnt_q;
        // A sprite pixel on the tick cycle still belongs to the frame that is ending.
        seen_now   = seen_q | is_rz;
        seen_d     = frame_tick ? 1'b0 : seen_now;
        if (frame_tick) begin
            unique case (state_q)
                StHidden: begin
                    if (seen_now) begin
                        state_d    = StFadeIn;
                        fade_cnt_d = 4'd0;
                    end
                end
                StFadeIn: begin
                    if (!seen_now) begin
                        state_d    = StHidden;
                        fade_cnt_d = 4'd0;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 4'd1;
                        if (fade_cnt_q == 4'd14) state_d = StShown;
                    end
                end
                StShown: begin
                    if (!seen_now) begin
                        state_d    = StHidden;
                        fade_cnt_d = 4'd0;
                    end
                end
                default: state_d = StHidden;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            StShown:  alpha = 5'd16;
            StFadeIn: alpha = {1'b0, fade_cnt_q} + 5'd1;
            default:  alpha = 5'd1;
        endcase
    end

    assign sprite_rgb = {blend(spr_s2_q[23:16], bg_s2_q[23:16], alpha),
                         blend(spr_s2_q[15:8],  bg_s2_q[15:8],  alpha),
                         blend(spr_s2_q[7:0],   bg_s2_q[7:0],   alpha)};
`else
    logic unused_frame_clk;

    assign unused_frame_clk = frame_clk;
    assign sprite_rgb       = spr_s2_q;
`endif

    always_comb begin
        rgb_d   = bg_s2_q;
        drawn_d = 1'b0;
        if (is_rz_s2_q && opaque_s2_q) begin
            rgb_d   = sprite_rgb;
            drawn_d = 1'b1;
        end
    end

    assign VGA_R    = rgb_q[23:16];
    assign VGA_G    = rgb_q[15:8];
    assign VGA_B    = rgb_q[7:0];
    assign rz_drawn = drawn_q;

endmodule

// File: tb/tb_rz_sprite_render.sv
// Self-checking bench for rz_sprite_render: vector table, random pixels against a frame-level
// model, and fade / reset sequences (fade checks follow RZ_FADE_EN).
module tb_rz_sprite_render;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        is_rz;
    logic [15:0] rz_addr;
    logic [23:0] bg_rgb;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        rz_drawn;

    always #10 Clk = ~Clk;

    rz_sprite_render dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .is_rz    (is_rz),
        .rz_addr  (rz_addr),
        .bg_rgb   (bg_rgb),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .VGA_R    (VGA_R),
        .VGA_G    (VGA_G),
        .VGA_B    (VGA_B),
        .rz_drawn (rz_drawn)
    );

    // Sprite ROM: address 100 holds index 5, everything else holds its low nibble.
    function automatic logic [3:0] rom_f(input logic [15:0] a);
        return (a == 16'd100) ? 4'd5 : a[3:0];
    endfunction

    always_ff @(posedge Clk) rom_data <= rom_f(rom_addr);

    typedef struct packed {
        logic [23:0] rgb;
        logic        drawn;
    } exp_t;

    typedef struct packed {
        logic        iz;
        logic [15:0] addr;
        logic [23:0] bg;
        logic [23:0] rgb;
        logic        drawn;
    } vec_t;

    logic [23:0] pal [16];
    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_frames = 0;   // consecutive completed frames that contained the sprite
    logic        frame_seen = 1'b0;
    logic [23:0] last_out;
    logic        last_drawn;
    logic [7:0]  exp_r;
    vec_t        vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic int alpha_model();
`ifdef RZ_FADE_EN
        return (n_frames < 1) ? 1 : ((n_frames > 16) ? 16 : n_frames);
`else
        return 16;
`endif
    endfunction

    function automatic exp_t model_px(input logic iz, input logic [15:0] ad,
                                      input logic [23:0] bg, input int a);
        exp_t        e;
        logic [3:0]  idx;
        logic [23:0] spr;
        int          ch;
        idx = rom_f(ad);
        if (!iz || idx == 4'd0) begin
            e.rgb   = bg;
            e.drawn = 1'b0;
        end else begin
            spr = pal[idx];
            for (int c = 0; c < 3; c++) begin
                ch = (int'(spr[8*c +: 8]) * a + int'(bg[8*c +: 8]) * (16 - a)) / 16;
                e.rgb[8*c +: 8] = ch[7:0];
            end
            e.drawn = 1'b1;
        end
        return e;
    endfunction

    // Apply one pixel, advance one clock, compare the pixel issued three clocks earlier.
    task automatic step(input logic iz, input logic [15:0] ad, input logic [23:0] bg);
        exp_t e;
        is_rz   = iz;
        rz_addr = ad;
        bg_rgb  = bg;
        if (iz) frame_seen = 1'b1;
        q.push_back(model_px(iz, ad, bg, alpha_model()));
        #1;
        check("rom_addr", {16'd0, rom_addr}, {16'd0, ad});
        @(posedge Clk);
        #1;
        if (q.size() >= 3) begin
            e = q.pop_front();
            last_out   = {VGA_R, VGA_G, VGA_B};
            last_drawn = rz_drawn;
            check("pix_rgb", {8'd0, last_out}, {8'd0, e.rgb});
            check("pix_drawn", {31'd0, last_drawn}, {31'd0, e.drawn});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 24'($urandom));
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom), 16'($urandom), 24'($urandom));
    endtask

    // Frame boundary: frame_tick lands on the third step after the frame_clk rise.
    task automatic frame_end(input logic tick_px);
        idle(3);
        frame_clk = 1'b1;
        idle(2);
        step(tick_px, 16'h0010, 24'($urandom));
        n_frames   = frame_seen ? n_frames + 1 : 0;
        frame_seen = 1'b0;
        frame_clk  = 1'b0;
        idle(3);
    endtask

    task automatic restart_model();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        n_frames   = 0;
        frame_seen = 1'b0;
    endtask

    initial begin
        pal = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'h808080, 24'hC0C0C0, 24'hE02020,
                24'h20E020, 24'h2020E0, 24'hE0E020, 24'h20E0E0, 24'hE020E0, 24'h804000,
                24'hFF8000, 24'h400080, 24'h008040, 24'h404040};
        vt[0] = '{1'b1, 16'd100,   24'h0000FF, 24'hE02020, 1'b1};
        vt[1] = '{1'b1, 16'h0010,  24'h123456, 24'h123456, 1'b0};
        vt[2] = '{1'b0, 16'd100,   24'hABCDEF, 24'hABCDEF, 1'b0};
        vt[3] = '{1'b1, 16'h0002,  24'h00FF00, 24'hFFFFFF, 1'b1};
        vt[4] = '{1'b1, 16'h0001,  24'hFFFFFF, 24'h000000, 1'b1};
        vt[5] = '{1'b1, 16'h0025,  24'h000000, 24'hE02020, 1'b1};

        Reset     = 1'b1;
        frame_clk = 1'b0;
        is_rz     = 1'b0;
        rz_addr   = '0;
        bg_rgb    = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("reset_drawn", {31'd0, rz_drawn}, 32'd0);
        Reset = 1'b0;
        restart_model();

        // Sprite (index 2 over black) present in consecutive frames.
        for (int k = 1; k <= 18; k++) begin
            step(1'b1, 16'h0002, 24'h000000);
            idle(2);
`ifdef RZ_FADE_EN
            exp_r = (k == 1) ? 8'h0F : ((k <= 16) ? 8'(16 * (k - 1) - 1) : 8'hFF);
`else
            exp_r = 8'hFF;
`endif
            check("fade_ramp", {24'd0, last_out[23:16]}, {24'd0, exp_r});
            rand_pixels(8);
            frame_end(1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            step(vt[i].iz, vt[i].addr, vt[i].bg);
            idle(2);
            check("vec_rgb", {8'd0, last_out}, {8'd0, vt[i].rgb});
            check("vec_drawn", {31'd0, last_drawn}, {31'd0, vt[i].drawn});
        end
        frame_end(1'b0);

        for (int f = 0; f < 4; f++) begin
            rand_pixels(40);
            frame_end(1'b0);
        end

        // Empty frame drops back to hidden; the next sprite frame blends at alpha 1.
        idle(10);
        frame_end(1'b0);
        step(1'b1, 16'h0002, 24'h000000);
        idle(2);
`ifdef RZ_FADE_EN
        exp_r = 8'h0F;
`else
        exp_r = 8'hFF;
`endif
        check("hide_then_show", {24'd0, last_out[7:0]}, {24'd0, exp_r});
        rand_pixels(20);
        frame_end(1'b0);

        // Frame whose only sprite pixel sits on the tick cycle still counts.
        idle(10);
        frame_end(1'b1);
        step(1'b1, 16'h0002, 24'h000000);
        idle(2);
`ifdef RZ_FADE_EN
        exp_r = 8'h1F;
`else
        exp_r = 8'hFF;
`endif
        check("tick_pixel", {24'd0, last_out[15:8]}, {24'd0, exp_r});
        rand_pixels(20);
        frame_end(1'b0);

        for (int f = 0; f < 3; f++) begin
            rand_pixels(40);
            frame_end(1'b0);
        end

        // Asynchronous reset with opaque pixels in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0002, 24'h000000);
        #3;
        Reset = 1'b1;
        #1;
        check("midreset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("midreset_drawn", {31'd0, rz_drawn}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        restart_model();
        step(1'b1, 16'h0002, 24'h000000);
        idle(2);
`ifdef RZ_FADE_EN
        exp_r = 8'h0F;
`else
        exp_r = 8'hFF;
`endif
        check("post_reset_hidden", {24'd0, last_out[23:16]}, {24'd0, exp_r});
        rand_pixels(30);
        frame_end(1'b0);
        rand_pixels(30);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
